// File: rtl/lif_pkg.sv
// Shared types and saturation limits for the leaky integrate-and-fire layer.
package lif_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

  localparam int DEF_POT_SIZE = 16;

  // Signed limits of a w-bit two's-complement potential.
  function automatic longint pot_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint pot_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint DEF_POT_MAX = pot_max(DEF_POT_SIZE);
  localparam longint DEF_POT_MIN = pot_min(DEF_POT_SIZE);

endpackage

// File: rtl/lif_neuron.sv
// One neuron: weight row, membrane potential, refractory counter and single-spike flag.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int THRESH       = 15,
  parameter int RESET        = 0,
  parameter int LEAK         = 1,
  parameter int REFRAC       = 5,
  parameter int WEIGHT_SIZE  = 8,
  parameter int POT_SIZE     = 16,
  parameter int NUM_INPUTS   = 4,
  parameter int SINGLE_SPIKE = 0,
  parameter int IDX_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          accum,
  input  logic                          fire,
  input  logic                          in_spike,
  input  logic [IDX_W-1:0]              acc_idx,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic signed [WEIGHT_SIZE-1:0] wr_data,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic signed [WEIGHT_SIZE-1:0] rd_data,
  output logic                          spike
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  // Two guard bits hold any single add or leak without overflow.
  localparam int W = POT_SIZE + 2;
  localparam logic signed [W-1:0]        SAT_HI = W'(pot_max(POT_SIZE));
  localparam logic signed [W-1:0]        SAT_LO = W'(pot_min(POT_SIZE));
  localparam logic signed [W-1:0]        RST_W  = W'(RESET);
  localparam logic signed [W-1:0]        THR_W  = W'(THRESH);
  localparam logic signed [W-1:0]        LEAK_W = W'(LEAK);
  localparam logic signed [POT_SIZE-1:0] RST_P  = POT_SIZE'(RESET);

  logic signed [WEIGHT_SIZE-1:0] weight [NUM_INPUTS];
  logic signed [POT_SIZE-1:0]    pot;
  logic [RW-1:0]                 refrac_cnt;
  logic                          flag;

  logic signed [WEIGHT_SIZE-1:0] wsel;
  logic signed [W-1:0]           pot_w, wext, acc_next, leaked;
  logic                          refractory, inhibited;

  assign wsel    = weight[acc_idx];
  assign rd_data = weight[rd_idx];
  assign pot_w   = {{2{pot[POT_SIZE-1]}}, pot};
  assign wext    = {{(W-WEIGHT_SIZE){wsel[WEIGHT_SIZE-1]}}, wsel};

  always_comb begin
    acc_next = pot_w + wext;
    if (acc_next > SAT_HI)      acc_next = SAT_HI;
    else if (acc_next < SAT_LO) acc_next = SAT_LO;
    leaked = pot_w - LEAK_W;
    if (leaked < RST_W) leaked = RST_W;
    refractory = (refrac_cnt != '0);
    inhibited  = (SINGLE_SPIKE != 0) && flag;
    spike      = fire && !refractory && !inhibited && (leaked >= THR_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pot        <= RST_P;
      refrac_cnt <= '0;
      flag       <= 1'b0;
    end else if (clear) begin
      pot        <= RST_P;
      refrac_cnt <= '0;
      flag       <= 1'b0;
    end else if (accum) begin
      if (!refractory && in_spike) pot <= acc_next[POT_SIZE-1:0];
    end else if (fire) begin
      if (refractory) begin
        refrac_cnt <= refrac_cnt - 1'b1;
      end else if (spike) begin
        pot        <= RST_P;
        refrac_cnt <= RW'(REFRAC);
        flag       <= 1'b1;
      end else begin
        pot <= leaked[POT_SIZE-1:0];
      end
    end
  end

  // Accumulation reads the row combinationally, so a same-edge write is seen next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) weight[i] <= '0;
    end else if (wr_en) begin
      weight[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/lif_layer.sv
// Layer of LIF neurons: timestep FSM, input index counter and weight-memory address decode.
module lif_layer
  import lif_pkg::*;
#(
  parameter int THRESH            = 15,
  parameter int RESET             = 0,
  parameter int LEAK              = 1,
  parameter int REFRAC            = 5,
  parameter int WEIGHT_SIZE       = 8,
  parameter int POT_SIZE          = 16,
  parameter int NUM_INPUTS        = 4,
  parameter int NUM_NEURONS       = 2,
  parameter int SINGLE_SPIKE      = 0,
  parameter int LAYER_ADDR_WIDTH  = 28,
  parameter int WEIGHT_ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        step_valid,
  output logic                        step_ready,
  input  logic [NUM_INPUTS-1:0]       spike_in,
  output logic [NUM_NEURONS-1:0]      spike_out,
  output logic                        spike_valid,
  input  logic                        layer_clear,
  input  logic [LAYER_ADDR_WIDTH-1:0] mem_addr,
  input  logic [WEIGHT_SIZE-1:0]      mem_din,
  input  logic                        mem_wen,
  output logic [WEIGHT_SIZE-1:0]      mem_dout
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int SEL_W = LAYER_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;

  state_t                                  state, next_state;
  logic [IDX_W-1:0]                        j;
  logic [NUM_INPUTS-1:0]                   latched;
  logic [SEL_W-1:0]                        sel;
  logic [WEIGHT_ADDR_WIDTH-1:0]            widx;
  logic                                    addr_ok, last_j;
  logic [NUM_NEURONS-1:0]                  spike_now;
  logic [NUM_NEURONS-1:0][WEIGHT_SIZE-1:0] rd_row;
  logic [WEIGHT_SIZE-1:0]                  rd_sel;

  assign sel     = mem_addr[LAYER_ADDR_WIDTH-1:WEIGHT_ADDR_WIDTH];
  assign widx    = mem_addr[WEIGHT_ADDR_WIDTH-1:0];
  assign addr_ok = (sel < SEL_W'(NUM_NEURONS)) && (widx < WEIGHT_ADDR_WIDTH'(NUM_INPUTS));
  assign last_j  = (j == IDX_W'(NUM_INPUTS - 1));

  always_comb begin
    next_state = state;
    step_ready = (state == IDLE);
    case (state)
      IDLE:    if (step_valid) next_state = ACCUM;
      ACCUM:   if (last_j)     next_state = FIRE;
      FIRE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (layer_clear) next_state = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      j       <= '0;
      latched <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && step_valid) begin
        latched <= spike_in;
        j       <= '0;
      end else if (state == ACCUM) begin
        j <= j + 1'b1;
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int n = 0; n < NUM_NEURONS; n++)
      if (sel == SEL_W'(n)) rd_sel = rd_row[n];
  end

  // A clear arriving in FIRE discards the timestep, so no spike_valid is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_valid <= 1'b0;
      spike_out   <= '0;
      mem_dout    <= '0;
    end else begin
      spike_valid <= (state == FIRE) && !layer_clear;
      if (state == FIRE && !layer_clear) spike_out <= spike_now;
      mem_dout <= addr_ok ? rd_sel : '0;
    end
  end

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_neuron
    lif_neuron #(
      .THRESH      (THRESH),
      .RESET       (RESET),
      .LEAK        (LEAK),
      .REFRAC      (REFRAC),
      .WEIGHT_SIZE (WEIGHT_SIZE),
      .POT_SIZE    (POT_SIZE),
      .NUM_INPUTS  (NUM_INPUTS),
      .SINGLE_SPIKE(SINGLE_SPIKE),
      .IDX_W       (IDX_W)
    ) u_neuron (
      .clk     (clk),
      .rst     (rst),
      .clear   (layer_clear),
      .accum   (state == ACCUM),
      .fire    (state == FIRE),
      .in_spike(latched[j]),
      .acc_idx (j),
      .wr_en   (mem_wen && addr_ok && (sel == SEL_W'(g))),
      .wr_idx  (widx[IDX_W-1:0]),
      .wr_data (mem_din),
      .rd_idx  (widx[IDX_W-1:0]),
      .rd_data (rd_row[g]),
      .spike   (spike_now[g])
    );
  end

endmodule

// File: tb/tb_lif_layer.sv
// Bench for lif_layer: a default layer plus an 8-bit single-spike layer, checked against a timestep-level model.
module tb_lif_layer;
  localparam int NI = 4;
  localparam int NN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    step_valid  = '0;
  logic [1:0]    layer_clear = '0;
  logic [1:0]    mem_wen     = '0;
  logic [NI-1:0] spike_in [2];
  logic [27:0]   mem_addr [2];
  logic [7:0]    mem_din  [2];
  wire  [1:0]    step_ready;
  wire  [1:0]    spike_valid;
  wire  [NN-1:0] spike_out [2];
  wire  [7:0]    mem_dout  [2];

  int checks = 0;
  int errors = 0;

  // Model: per-instance rule parameters and neuron state.
  int th[2]   = '{15, 127};
  int rs[2]   = '{0, 0};
  int lk[2]   = '{1, 0};
  int rf[2]   = '{5, 0};
  int ss[2]   = '{0, 1};
  int pmax[2] = '{32767, 127};
  int pmin[2] = '{-32768, -128};
  int w[2][NN][NI];
  int pot[2][NN];
  int rc[2][NN];
  bit fl[2][NN];

  lif_layer dut_a (
    .clk(clk), .rst(rst), .step_valid(step_valid[0]), .step_ready(step_ready[0]),
    .spike_in(spike_in[0]), .spike_out(spike_out[0]), .spike_valid(spike_valid[0]),
    .layer_clear(layer_clear[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
    .mem_wen(mem_wen[0]), .mem_dout(mem_dout[0])
  );

  lif_layer #(
    .THRESH(127), .RESET(0), .LEAK(0), .REFRAC(0), .POT_SIZE(8), .SINGLE_SPIKE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .step_valid(step_valid[1]), .step_ready(step_ready[1]),
    .spike_in(spike_in[1]), .spike_out(spike_out[1]), .spike_valid(spike_valid[1]),
    .layer_clear(layer_clear[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
    .mem_wen(mem_wen[1]), .mem_dout(mem_dout[1])
  );

  task automatic model_clear(input int k);
    for (int n = 0; n < NN; n++) begin
      pot[k][n] = rs[k];
      rc[k][n]  = 0;
      fl[k][n]  = 1'b0;
    end
  endtask

  // Whole timestep at once: integrate the spiking inputs, then leak/fire.
  function automatic logic [NN-1:0] model_step(input int k, input logic [NI-1:0] s);
    logic [NN-1:0] e;
    int lv;
    e = '0;
    for (int n = 0; n < NN; n++) begin
      if (rc[k][n] == 0)
        for (int i = 0; i < NI; i++)
          if (s[i]) begin
            pot[k][n] = pot[k][n] + w[k][n][i];
            if (pot[k][n] > pmax[k]) pot[k][n] = pmax[k];
            if (pot[k][n] < pmin[k]) pot[k][n] = pmin[k];
          end
      if (rc[k][n] > 0) begin
        rc[k][n] = rc[k][n] - 1;
      end else begin
        lv = pot[k][n] - lk[k];
        if (lv < rs[k]) lv = rs[k];
        if (lv >= th[k] && !(ss[k] != 0 && fl[k][n])) begin
          e[n] = 1'b1;
          pot[k][n] = rs[k];
          rc[k][n]  = rf[k];
          fl[k][n]  = 1'b1;
        end else begin
          pot[k][n] = lv;
        end
      end
    end
    return e;
  endfunction

  task automatic write_w(input int k, input int n, input int i, input int v);
    @(negedge clk);
    mem_addr[k] = 28'((n << 10) | i);
    mem_din[k]  = 8'(v);
    mem_wen[k]  = 1'b1;
    @(negedge clk);
    mem_wen[k] = 1'b0;
    if (n < NN && i < NI) w[k][n][i] = v;
  endtask

  task automatic read_w(input int k, input int n, input int i, output logic [7:0] d);
    @(negedge clk);
    mem_addr[k] = 28'((n << 10) | i);
    mem_wen[k]  = 1'b0;
    @(negedge clk);
    d = mem_dout[k];
  endtask

  task automatic do_clear(input int k);
    @(negedge clk);
    layer_clear[k] = 1'b1;
    @(negedge clk);
    layer_clear[k] = 1'b0;
    model_clear(k);
  endtask

  task automatic run_step(input int k, input logic [NI-1:0] s, input string tag);
    logic [NN-1:0] exp;
    int cnt;
    bit seen;
    exp = model_step(k, s);
    @(negedge clk);
    checks++;
    if (step_ready[k] !== 1'b1) begin
      errors++; $display("FAIL %s ready_idle got %b want 1", tag, step_ready[k]);
    end
    step_valid[k] = 1'b1;
    spike_in[k]   = s;
    @(negedge clk);
    step_valid[k] = 1'b0;
    checks++;
    if (step_ready[k] !== 1'b0) begin
      errors++; $display("FAIL %s ready_busy got %b want 0", tag, step_ready[k]);
    end
    cnt = 0; seen = 0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (spike_valid[k] === 1'b1) seen = 1;
    end
    // NI+1 edges after the handshake edge, i.e. NI+2 cycles counting the handshake cycle.
    checks++;
    if (!seen || cnt != NI + 1) begin
      errors++; $display("FAIL %s latency got %0d seen %0d want %0d", tag, cnt, seen, NI + 1);
    end
    checks++;
    if (spike_out[k] !== exp) begin
      errors++; $display("FAIL %s spikes got %b want %b", tag, spike_out[k], exp);
    end
    @(negedge clk);
    checks++;
    if (spike_valid[k] !== 1'b0 || spike_out[k] !== exp) begin
      errors++; $display("FAIL %s hold got valid %b spikes %b want 0 %b", tag, spike_valid[k], spike_out[k], exp);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (step_ready[k] !== 1'b1 || spike_valid[k] !== 1'b0 || spike_out[k] !== '0 || mem_dout[k] !== 8'h00) begin
        errors++;
        $display("FAIL reset%0d got ready %b valid %b spikes %b dout %h want 1 0 0 00",
                 k, step_ready[k], spike_valid[k], spike_out[k], mem_dout[k]);
      end
    end
  endtask

  task automatic test_mem();
    logic [7:0] d;
    write_w(0, 1, 3, -7);
    write_w(0, NN, 0, 33);
    write_w(0, 0, 5, 44);
    read_w(0, 1, 3, d);
    checks++;
    if (d !== 8'hF9) begin errors++; $display("FAIL mem_rd got %h want f9", d); end
    read_w(0, NN, 0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL mem_oor_sel got %h want 00", d); end
    read_w(0, 0, 5, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL mem_oor_idx got %h want 00", d); end
    read_w(0, 0, 0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL mem_no_alias got %h want 00", d); end
  endtask

  task automatic test_spike_refrac();
    for (int i = 0; i < NI; i++) write_w(0, 0, i, 5);
    for (int s = 0; s < 7; s++) run_step(0, 4'b1111, $sformatf("refrac_step%0d", s));
  endtask

  task automatic test_sat_single();
    for (int i = 0; i < NI; i++) begin
      write_w(1, 0, i, 127);
      write_w(1, 1, i, 1);
    end
    for (int s = 0; s < 3; s++) run_step(1, 4'b1111, $sformatf("sat_step%0d", s));
    do_clear(1);
    run_step(1, 4'b1111, "sat_after_clear");
    run_step(1, 4'b1111, "sat_inhibit_again");
  endtask

  task automatic test_clear_mid();
    bit seen;
    for (int i = 0; i < NI; i++) write_w(0, 0, i, 3);
    do_clear(0);
    run_step(0, 4'b1111, "clr_pre");
    @(negedge clk);
    step_valid[0] = 1'b1;
    spike_in[0]   = 4'b1111;
    @(negedge clk);
    step_valid[0] = 1'b0;
    @(negedge clk);
    layer_clear[0] = 1'b1;
    @(negedge clk);
    layer_clear[0] = 1'b0;
    model_clear(0);
    checks++;
    if (step_ready[0] !== 1'b1) begin errors++; $display("FAIL clr_idle got %b want 1", step_ready[0]); end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (spike_valid[0] === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL clr_no_valid got 1 want 0"); end
    run_step(0, 4'b1111, "clr_post");
  endtask

  task automatic test_random();
    logic [7:0] d;
    int n, i;
    for (int nn = 0; nn < NN; nn++)
      for (int ii = 0; ii < NI; ii++) write_w(0, nn, ii, int'($urandom_range(40, 0)) - 20);
    for (int s = 0; s < 24; s++) begin
      if ($urandom_range(7, 0) == 0) do_clear(0);
      run_step(0, NI'($urandom), $sformatf("rand_a%0d", s));
    end
    n = int'($urandom_range(NN - 1, 0));
    i = int'($urandom_range(NI - 1, 0));
    read_w(0, n, i, d);
    checks++;
    if (d !== 8'(w[0][n][i])) begin errors++; $display("FAIL rand_rd got %h want %h", d, 8'(w[0][n][i])); end
    do_clear(1);
    for (int nn = 0; nn < NN; nn++)
      for (int ii = 0; ii < NI; ii++) write_w(1, nn, ii, int'($urandom_range(255, 0)) - 128);
    for (int s = 0; s < 12; s++) begin
      if ($urandom_range(3, 0) == 0) do_clear(1);
      run_step(1, NI'($urandom), $sformatf("rand_b%0d", s));
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      spike_in[k] = '0;
      mem_addr[k] = '0;
      mem_din[k]  = '0;
      model_clear(k);
      for (int n = 0; n < NN; n++)
        for (int i = 0; i < NI; i++) w[k][n][i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_mem();
    test_spike_refrac();
    test_sat_single();
    test_clear_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
